// File: rtl/roce_pkg.sv
// roce_pkg
//   Shared RoCE RC definitions for the transmit path. The segmenter and the
//   BTH/RETH header builder both use it.
//   Contents:
//     - RC opcode constants for SEND and RDMA WRITE.
//     - PMTU code enum and pmtu_bytes(), which maps a code to a payload size.
//     - Segmenter FSM state encoding.
package roce_pkg;

  localparam logic [7:0] ROCE_SEND_FIRST               = 8'h00;
  localparam logic [7:0] ROCE_SEND_MIDDLE              = 8'h01;
  localparam logic [7:0] ROCE_SEND_LAST                = 8'h02;
  localparam logic [7:0] ROCE_SEND_LAST_IMM            = 8'h03;
  localparam logic [7:0] ROCE_SEND_ONLY                = 8'h04;
  localparam logic [7:0] ROCE_SEND_ONLY_IMM            = 8'h05;
  localparam logic [7:0] ROCE_RDMA_WRITE_FIRST         = 8'h06;
  localparam logic [7:0] ROCE_RDMA_WRITE_MIDDLE        = 8'h07;
  localparam logic [7:0] ROCE_RDMA_WRITE_LAST          = 8'h08;
  localparam logic [7:0] ROCE_RDMA_WRITE_LAST_IMM      = 8'h09;
  localparam logic [7:0] ROCE_RDMA_WRITE_ONLY          = 8'h0A;
  localparam logic [7:0] ROCE_RDMA_WRITE_ONLY_IMM      = 8'h0B;

  typedef enum logic [2:0] {
    PMTU_256  = 3'd0,
    PMTU_512  = 3'd1,
    PMTU_1024 = 3'd2,
    PMTU_2048 = 3'd3,
    PMTU_4096 = 3'd4
  } pmtu_e;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_SEGMENT = 1'b1
  } seg_state_e;

  // Codes 5-7 are reserved and fall back to the largest MTU.
  function automatic logic [12:0] pmtu_bytes(input logic [2:0] code);
    case (code)
      PMTU_256:  pmtu_bytes = 13'd256;
      PMTU_512:  pmtu_bytes = 13'd512;
      PMTU_1024: pmtu_bytes = 13'd1024;
      PMTU_2048: pmtu_bytes = 13'd2048;
      default:   pmtu_bytes = 13'd4096;
    endcase
  endfunction

endpackage

// File: rtl/roce_opcode_sel.sv
// roce_opcode_sel
//   Combinational RC opcode selection. The header builder reuses it.
//   Ports:
//     tx_type      in   0 = SEND, 1 = RDMA WRITE
//     is_immediate in   pick the IMM variant of the LAST/ONLY opcodes
//     first        in   packet is the first of its work request
//     last         in   packet is the last of its work request
//     op_code      out  8-bit BTH opcode
module roce_opcode_sel
  import roce_pkg::*;
(
  input  logic       tx_type,
  input  logic       is_immediate,
  input  logic       first,
  input  logic       last,
  output logic [7:0] op_code
);

  // Opcode lookup on {tx_type, first, last}
  always_comb begin
    op_code = ROCE_SEND_MIDDLE;
    case ({tx_type, first, last})
      3'b011:  op_code = is_immediate ? ROCE_SEND_ONLY_IMM : ROCE_SEND_ONLY;
      3'b010:  op_code = ROCE_SEND_FIRST;
      3'b001:  op_code = is_immediate ? ROCE_SEND_LAST_IMM : ROCE_SEND_LAST;
      3'b000:  op_code = ROCE_SEND_MIDDLE;
      3'b111:  op_code = is_immediate ? ROCE_RDMA_WRITE_ONLY_IMM : ROCE_RDMA_WRITE_ONLY;
      3'b110:  op_code = ROCE_RDMA_WRITE_FIRST;
      3'b101:  op_code = is_immediate ? ROCE_RDMA_WRITE_LAST_IMM : ROCE_RDMA_WRITE_LAST;
      3'b100:  op_code = ROCE_RDMA_WRITE_MIDDLE;
      default: op_code = ROCE_SEND_MIDDLE;
    endcase
  end

endmodule

// File: rtl/roce_tx_wr_segmenter.sv
// roce_tx_wr_segmenter
//   Splits one DMA work request into a stream of RoCE RC packet descriptors,
//   each sized to the path MTU. The descriptors go out over a valid/ready
//   interface, at most one per cycle.
//   Ports:
//     start_transfer + QP params (dma_transfer, r_key, rem_qpn, loc_psn,
//       rem_addr, rem_ip_addr, is_immediate, tx_type, pmtu, pmtu_valid)
//         work-request inputs; they are captured on start in IDLE.
//     m_desc_* / m_bth_* / m_reth_* / m_payload_length / m_ip_dest_ip /
//       m_is_last
//         registered descriptor outputs; they are held while stalled.
//     psn_next       PSN following the last packet of the previous request.
//     transfer_done  pulse in the cycle after the final handshake.
//     start_dropped  pulse in the cycle after a start that was ignored.
//     busy           a work request is in progress.
module roce_tx_wr_segmenter
  import roce_pkg::*;
#(
  parameter int          LEN_W        = 32,
  parameter logic [2:0]  DEFAULT_PMTU = 3'd4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_transfer,
  input  logic [LEN_W-1:0] dma_transfer,
  input  logic [31:0]      r_key,
  input  logic [23:0]      rem_qpn,
  input  logic [23:0]      loc_psn,
  input  logic [63:0]      rem_addr,
  input  logic [31:0]      rem_ip_addr,
  input  logic             is_immediate,
  input  logic             tx_type,
  input  logic [2:0]       pmtu,
  input  logic             pmtu_valid,
  output logic             m_desc_valid,
  input  logic             m_desc_ready,
  output logic [7:0]       m_bth_op_code,
  output logic [23:0]      m_bth_psn,
  output logic [23:0]      m_bth_dest_qp,
  output logic             m_bth_ack_req,
  output logic             m_reth_valid,
  output logic [63:0]      m_reth_v_addr,
  output logic [31:0]      m_reth_r_key,
  output logic [LEN_W-1:0] m_reth_length,
  output logic [12:0]      m_payload_length,
  output logic [31:0]      m_ip_dest_ip,
  output logic             m_is_last,
  output logic [23:0]      psn_next,
  output logic             transfer_done,
  output logic             start_dropped,
  output logic             busy
);

  seg_state_e       state_q, state_d;
  // Working counters always describe the next segment to emit.
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [23:0]      psn_q, psn_d;
  logic [63:0]      vaddr_q, vaddr_d;
  logic             first_q, first_d;
  logic             tx_type_q, tx_type_d;
  logic             is_imm_q, is_imm_d;
  logic [12:0]      pmtu_b_q, pmtu_b_d;
  // Descriptor output registers
  logic             valid_q, valid_d;
  logic [7:0]       op_q, op_d;
  logic [23:0]      bth_psn_q, bth_psn_d;
  logic [23:0]      dest_qp_q, dest_qp_d;
  logic             ack_q, ack_d;
  logic             reth_valid_q, reth_valid_d;
  logic [63:0]      v_addr_q, v_addr_d;
  logic [31:0]      r_key_q, r_key_d;
  logic [LEN_W-1:0] reth_len_q, reth_len_d;
  logic [12:0]      pay_len_q, pay_len_d;
  logic [31:0]      ip_q, ip_d;
  logic             is_last_q, is_last_d;
  logic [23:0]      psn_next_q, psn_next_d;
  logic             done_q, done_d;
  logic             dropped_q, dropped_d;

  logic             capture_s, advance_s, finish_s, hs_s;
  logic [LEN_W-1:0] src_rem_s;
  logic [23:0]      src_psn_s;
  logic [63:0]      src_vaddr_s;
  logic             src_first_s, src_tx_s, src_imm_s;
  logic [12:0]      src_pmtu_b_s;
  logic             seg_last_s;
  logic [12:0]      seg_len_s;
  logic [7:0]       seg_op_s;

  // Decode the events that move the segmenter forward
  always_comb begin
    capture_s = (state_q == ST_IDLE) && start_transfer;
    hs_s      = (state_q == ST_SEGMENT) && valid_q && m_desc_ready;
    advance_s = hs_s && !is_last_q;
    finish_s  = hs_s && is_last_q;
  end

  // Segment source: live inputs on capture, else the working counters
  always_comb begin
    if (capture_s) begin
      src_rem_s    = dma_transfer;
      src_psn_s    = loc_psn;
      src_vaddr_s  = rem_addr;
      src_first_s  = 1'b1;
      src_tx_s     = tx_type;
      src_imm_s    = is_immediate;
      src_pmtu_b_s = pmtu_bytes(pmtu_valid ? pmtu : DEFAULT_PMTU);
    end else begin
      src_rem_s    = remaining_q;
      src_psn_s    = psn_q;
      src_vaddr_s  = vaddr_q;
      src_first_s  = first_q;
      src_tx_s     = tx_type_q;
      src_imm_s    = is_imm_q;
      src_pmtu_b_s = pmtu_b_q;
    end
    // When the segment is last, the remaining count is at most 4096, so it fits in 13 bits.
    seg_last_s = (src_rem_s <= LEN_W'(src_pmtu_b_s));
    seg_len_s  = seg_last_s ? src_rem_s[12:0] : src_pmtu_b_s;
  end

  roce_opcode_sel u_opcode_sel (
    .tx_type      (src_tx_s),
    .is_immediate (src_imm_s),
    .first        (src_first_s),
    .last         (seg_last_s),
    .op_code      (seg_op_s)
  );

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = capture_s ? ST_SEGMENT : ST_IDLE;
      ST_SEGMENT: state_d = finish_s ? ST_IDLE : ST_SEGMENT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath: load a descriptor on capture/handshake, close on final handshake
  always_comb begin
    remaining_d  = remaining_q;
    psn_d        = psn_q;
    vaddr_d      = vaddr_q;
    first_d      = first_q;
    tx_type_d    = tx_type_q;
    is_imm_d     = is_imm_q;
    pmtu_b_d     = pmtu_b_q;
    valid_d      = valid_q;
    op_d         = op_q;
    bth_psn_d    = bth_psn_q;
    dest_qp_d    = dest_qp_q;
    ack_d        = ack_q;
    reth_valid_d = reth_valid_q;
    v_addr_d     = v_addr_q;
    r_key_d      = r_key_q;
    reth_len_d   = reth_len_q;
    pay_len_d    = pay_len_q;
    ip_d         = ip_q;
    is_last_d    = is_last_q;
    psn_next_d   = psn_next_q;
    done_d       = 1'b0;
    dropped_d    = (state_q == ST_SEGMENT) && start_transfer;

    if (capture_s || advance_s) begin
      valid_d      = 1'b1;
      op_d         = seg_op_s;
      bth_psn_d    = src_psn_s;
      ack_d        = seg_last_s;
      reth_valid_d = src_tx_s && src_first_s;
      v_addr_d     = src_vaddr_s;
      pay_len_d    = seg_len_s;
      is_last_d    = seg_last_s;
      remaining_d  = src_rem_s - LEN_W'(seg_len_s);
      psn_d        = src_psn_s + 24'd1;
      vaddr_d      = src_vaddr_s + 64'(seg_len_s);
      first_d      = 1'b0;
      tx_type_d    = src_tx_s;
      is_imm_d     = src_imm_s;
      pmtu_b_d     = src_pmtu_b_s;
    end else if (finish_s) begin
      valid_d    = 1'b0;
      psn_next_d = bth_psn_q + 24'd1;
      done_d     = 1'b1;
    end else begin
      valid_d = valid_q;
    end

    // Per-request constants are written only when a request is captured.
    if (capture_s) begin
      dest_qp_d  = rem_qpn;
      r_key_d    = r_key;
      reth_len_d = dma_transfer;
      ip_d       = rem_ip_addr;
    end else begin
      dest_qp_d  = dest_qp_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and descriptor registers
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q  <= '0;
      psn_q        <= 24'd0;
      vaddr_q      <= 64'd0;
      first_q      <= 1'b0;
      tx_type_q    <= 1'b0;
      is_imm_q     <= 1'b0;
      pmtu_b_q     <= 13'd0;
      valid_q      <= 1'b0;
      op_q         <= 8'd0;
      bth_psn_q    <= 24'd0;
      dest_qp_q    <= 24'd0;
      ack_q        <= 1'b0;
      reth_valid_q <= 1'b0;
      v_addr_q     <= 64'd0;
      r_key_q      <= 32'd0;
      reth_len_q   <= '0;
      pay_len_q    <= 13'd0;
      ip_q         <= 32'd0;
      is_last_q    <= 1'b0;
      psn_next_q   <= 24'd0;
      done_q       <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      remaining_q  <= remaining_d;
      psn_q        <= psn_d;
      vaddr_q      <= vaddr_d;
      first_q      <= first_d;
      tx_type_q    <= tx_type_d;
      is_imm_q     <= is_imm_d;
      pmtu_b_q     <= pmtu_b_d;
      valid_q      <= valid_d;
      op_q         <= op_d;
      bth_psn_q    <= bth_psn_d;
      dest_qp_q    <= dest_qp_d;
      ack_q        <= ack_d;
      reth_valid_q <= reth_valid_d;
      v_addr_q     <= v_addr_d;
      r_key_q      <= r_key_d;
      reth_len_q   <= reth_len_d;
      pay_len_q    <= pay_len_d;
      ip_q         <= ip_d;
      is_last_q    <= is_last_d;
      psn_next_q   <= psn_next_d;
      done_q       <= done_d;
      dropped_q    <= dropped_d;
    end
  end

  assign m_desc_valid     = valid_q;
  assign m_bth_op_code    = op_q;
  assign m_bth_psn        = bth_psn_q;
  assign m_bth_dest_qp    = dest_qp_q;
  assign m_bth_ack_req    = ack_q;
  assign m_reth_valid     = reth_valid_q;
  assign m_reth_v_addr    = v_addr_q;
  assign m_reth_r_key     = r_key_q;
  assign m_reth_length    = reth_len_q;
  assign m_payload_length = pay_len_q;
  assign m_ip_dest_ip     = ip_q;
  assign m_is_last        = is_last_q;
  assign psn_next         = psn_next_q;
  assign transfer_done    = done_q;
  assign start_dropped    = dropped_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_roce_tx_wr_segmenter.sv
// Self-checking bench for roce_tx_wr_segmenter.
// Expected descriptors are pushed to a queue when a work request is started.
// They are popped and compared as the DUT presents them.
module tb_roce_tx_wr_segmenter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_transfer = 1'b0;
  logic [31:0] dma_transfer = 32'd0;
  logic [31:0] r_key = 32'd0;
  logic [23:0] rem_qpn = 24'd0;
  logic [23:0] loc_psn = 24'd0;
  logic [63:0] rem_addr = 64'd0;
  logic [31:0] rem_ip_addr = 32'd0;
  logic        is_immediate = 1'b0;
  logic        tx_type = 1'b0;
  logic [2:0]  pmtu = 3'd0;
  logic        pmtu_valid = 1'b0;
  logic        m_desc_ready = 1'b1;
  logic        m_desc_valid;
  logic [7:0]  m_bth_op_code;
  logic [23:0] m_bth_psn;
  logic [23:0] m_bth_dest_qp;
  logic        m_bth_ack_req;
  logic        m_reth_valid;
  logic [63:0] m_reth_v_addr;
  logic [31:0] m_reth_r_key;
  logic [31:0] m_reth_length;
  logic [12:0] m_payload_length;
  logic [31:0] m_ip_dest_ip;
  logic        m_is_last;
  logic [23:0] psn_next;
  logic        transfer_done;
  logic        start_dropped;
  logic        busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [23:0] psn;
    logic [12:0] len;
    logic [63:0] vaddr;
    logic        reth;
    logic        ack;
    logic        last;
    logic [23:0] qpn;
    logic [31:0] rkey;
    logic [31:0] ip;
    logic [31:0] total;
  } exp_t;

  exp_t exp_q[$];

  roce_tx_wr_segmenter dut (
    .clk(clk), .rst(rst), .start_transfer(start_transfer),
    .dma_transfer(dma_transfer), .r_key(r_key), .rem_qpn(rem_qpn),
    .loc_psn(loc_psn), .rem_addr(rem_addr), .rem_ip_addr(rem_ip_addr),
    .is_immediate(is_immediate), .tx_type(tx_type), .pmtu(pmtu),
    .pmtu_valid(pmtu_valid), .m_desc_valid(m_desc_valid),
    .m_desc_ready(m_desc_ready), .m_bth_op_code(m_bth_op_code),
    .m_bth_psn(m_bth_psn), .m_bth_dest_qp(m_bth_dest_qp),
    .m_bth_ack_req(m_bth_ack_req), .m_reth_valid(m_reth_valid),
    .m_reth_v_addr(m_reth_v_addr), .m_reth_r_key(m_reth_r_key),
    .m_reth_length(m_reth_length), .m_payload_length(m_payload_length),
    .m_ip_dest_ip(m_ip_dest_ip), .m_is_last(m_is_last),
    .psn_next(psn_next), .transfer_done(transfer_done),
    .start_dropped(start_dropped), .busy(busy)
  );

  always #5 clk = ~clk;

  // Opcode from the RC table: WRITE opcodes start 6 above the SEND ones.
  function automatic logic [7:0] exp_opcode(input logic tx, input logic imm,
                                            input logic first, input logic last);
    logic [7:0] base;
    base = tx ? 8'h06 : 8'h00;
    if (first && last)      exp_opcode = base + 8'h04 + {7'd0, imm};
    else if (first)         exp_opcode = base;
    else if (last)          exp_opcode = base + 8'h02 + {7'd0, imm};
    else                    exp_opcode = base + 8'h01;
  endfunction

  // Drive a work request, push its expected descriptors, then scramble the inputs.
  task automatic start_wr(input logic tx, input logic imm, input logic [2:0] pm,
                          input logic pv, input logic [31:0] len,
                          input logic [23:0] psn, input logic [63:0] addr,
                          output logic [23:0] exp_pn);
    logic [32:0] rem;
    logic [32:0] mtu;
    logic [2:0]  eff;
    logic        first;
    logic        last;
    logic [12:0] seg;
    exp_t        e;
    tx_type = tx; is_immediate = imm; pmtu = pm; pmtu_valid = pv;
    dma_transfer = len; loc_psn = psn; rem_addr = addr;
    r_key = $urandom; rem_qpn = 24'($urandom); rem_ip_addr = $urandom;
    eff = pv ? pm : 3'd4;
    mtu = (eff >= 3'd4) ? 33'd4096 : (33'd256 << eff);
    rem = {1'b0, len};
    first = 1'b1;
    do begin
      last = (rem <= mtu);
      seg  = last ? rem[12:0] : mtu[12:0];
      e.op = exp_opcode(tx, imm, first, last);
      e.psn = psn; e.len = seg; e.vaddr = addr;
      e.reth = tx && first; e.ack = last; e.last = last;
      e.qpn = rem_qpn; e.rkey = r_key; e.ip = rem_ip_addr; e.total = len;
      exp_q.push_back(e);
      rem = rem - {20'd0, seg};
      addr = addr + {51'd0, seg};
      psn = psn + 24'd1;
      first = 1'b0;
    end while (!last);
    exp_pn = psn;
    start_transfer = 1'b1;
    @(posedge clk); #1;
    start_transfer = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %0b expected 1", busy); end
    dma_transfer = $urandom; loc_psn = 24'($urandom); rem_addr = {$urandom, $urandom};
    r_key = $urandom; rem_qpn = 24'($urandom); rem_ip_addr = $urandom;
    tx_type = 1'($urandom); is_immediate = 1'($urandom); pmtu = 3'($urandom);
    pmtu_valid = 1'($urandom);
  endtask

  // Consume descriptors against the scoreboard.
  // Optional stall, mid-transfer start (drop) and early abort.
  task automatic drain(input int stall_after, input int stall_len, input int drop_at,
                       input int abort_after, input logic [23:0] exp_pn);
    int hs = 0;
    int stalled = 0;
    int cyc = 0;
    bit drop_pending = 1'b0;
    bit drop_done = 1'b0;
    bit aborted = 1'b0;
    exp_t e;
    while (exp_q.size() > 0 && !aborted) begin
      if (drop_pending) begin
        start_transfer = 1'b0; drop_pending = 1'b0; checks++;
        if (start_dropped !== 1'b1) begin errors++; $display("FAIL start_dropped: got %0b expected 1", start_dropped); end
      end
      if (hs == abort_after) begin
        aborted = 1'b1;
      end else if (cyc >= 300) begin
        checks++; errors++;
        $display("FAIL drain_timeout: got %0d descriptors left expected 0", exp_q.size());
        aborted = 1'b1;
      end else begin
        m_desc_ready = !(hs == stall_after && stalled < stall_len);
        if (!m_desc_ready) stalled++;
        if (hs == drop_at && !drop_done) begin
          start_transfer = 1'b1; dma_transfer = 32'd999; loc_psn = 24'h777777;
          drop_done = 1'b1; drop_pending = 1'b1;
        end
        e = exp_q[0];
        checks++;
        if (m_desc_valid !== 1'b1) begin errors++; $display("FAIL desc_valid: got %0b expected 1", m_desc_valid); end
        checks++;
        if (m_bth_op_code !== e.op) begin errors++; $display("FAIL opcode: got %0h expected %0h", m_bth_op_code, e.op); end
        checks++;
        if (m_bth_psn !== e.psn) begin errors++; $display("FAIL psn: got %0h expected %0h", m_bth_psn, e.psn); end
        checks++;
        if (m_payload_length !== e.len) begin errors++; $display("FAIL payload_len: got %0d expected %0d", m_payload_length, e.len); end
        checks++;
        if (m_reth_v_addr !== e.vaddr) begin errors++; $display("FAIL vaddr: got %0h expected %0h", m_reth_v_addr, e.vaddr); end
        checks++;
        if ({m_reth_valid, m_bth_ack_req, m_is_last} !== {e.reth, e.ack, e.last}) begin
          errors++; $display("FAIL flags reth/ack/last: got %b%b%b expected %b%b%b",
            m_reth_valid, m_bth_ack_req, m_is_last, e.reth, e.ack, e.last);
        end
        checks++;
        if ({m_bth_dest_qp, m_reth_r_key, m_ip_dest_ip, m_reth_length} !== {e.qpn, e.rkey, e.ip, e.total}) begin
          errors++; $display("FAIL consts qpn/rkey/ip/len: got %h %h %h %0d expected %h %h %h %0d",
            m_bth_dest_qp, m_reth_r_key, m_ip_dest_ip, m_reth_length, e.qpn, e.rkey, e.ip, e.total);
        end
        if (m_desc_ready) begin
          void'(exp_q.pop_front());
          hs++;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    exp_q.delete();
    m_desc_ready = 1'b1;
    if (drop_pending) begin
      start_transfer = 1'b0; checks++;
      if (start_dropped !== 1'b1) begin errors++; $display("FAIL start_dropped_final: got %0b expected 1", start_dropped); end
    end
    if (!aborted) begin
      checks++;
      if (m_desc_valid !== 1'b0) begin errors++; $display("FAIL valid_after_last: got %0b expected 0", m_desc_valid); end
      checks++;
      if (transfer_done !== 1'b1) begin errors++; $display("FAIL transfer_done: got %0b expected 1", transfer_done); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_last: got %0b expected 0", busy); end
      checks++;
      if (psn_next !== exp_pn) begin errors++; $display("FAIL psn_next: got %0h expected %0h", psn_next, exp_pn); end
      @(posedge clk); #1;
      checks++;
      if (transfer_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %0b expected 0", transfer_done); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({m_desc_valid, transfer_done, start_dropped, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {m_desc_valid, transfer_done, start_dropped, busy});
    end
    checks++;
    if ({psn_next, m_bth_psn, m_bth_op_code, m_payload_length} !== 69'd0) begin
      errors++; $display("FAIL reset_fields: got %h %h %h %h expected 0", psn_next, m_bth_psn, m_bth_op_code, m_payload_length);
    end
    checks++;
    if ({m_reth_v_addr, m_reth_length, m_reth_r_key} !== 128'd0) begin
      errors++; $display("FAIL reset_reth: got %h %h %h expected 0", m_reth_v_addr, m_reth_length, m_reth_r_key);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_segmented();
    logic [23:0] pn;
    start_wr(1'b1, 1'b0, 3'd1, 1'b1, 32'd1300, 24'h000010, 64'h1000, pn);
    drain(-1, 0, -1, -1, pn);
  endtask

  task automatic test_send_imm_zero();
    logic [23:0] pn;
    start_wr(1'b0, 1'b1, 3'd3, 1'b1, 32'd0, 24'h000100, 64'hDEAD_0000, pn);
    drain(-1, 0, -1, -1, pn);
  endtask

  task automatic test_psn_wrap();
    logic [23:0] pn;
    start_wr(1'b1, 1'b0, 3'd4, 1'b1, 32'd8192, 24'hFFFFFF, 64'h2000, pn);
    drain(-1, 0, -1, -1, pn);
  endtask

  task automatic test_write_only_and_stall();
    logic [23:0] pn;
    // Reserved PMTU code 6 behaves as 4096
    start_wr(1'b1, 1'b0, 3'd6, 1'b1, 32'd4096, 24'h000200, 64'h8000, pn);
    drain(-1, 0, -1, -1, pn);
    // Default PMTU in use, 64-bit address wraps, 5-cycle stall after 1st desc
    start_wr(1'b1, 1'b1, 3'd0, 1'b0, 32'd10000, 24'h000500, 64'hFFFF_FFFF_FFFF_F000, pn);
    drain(1, 5, -1, -1, pn);
  endtask

  task automatic test_drop();
    logic [23:0] pn;
    start_wr(1'b0, 1'b0, 3'd1, 1'b1, 32'd2000, 24'h001000, 64'h4_0000, pn);
    drain(-1, 0, 1, -1, pn);
  endtask

  task automatic test_back_to_back();
    logic [23:0] pn;
    // Start coinciding with the final handshake is dropped
    start_wr(1'b0, 1'b1, 3'd0, 1'b1, 32'd300, 24'h002000, 64'h5000, pn);
    drain(-1, 0, 1, -1, pn);
    start_wr(1'b1, 1'b1, 3'd2, 1'b1, 32'd1024, 24'h003000, 64'h6000, pn);
    drain(-1, 0, -1, -1, pn);
  endtask

  task automatic test_reset_abort();
    logic [23:0] pn;
    start_wr(1'b1, 1'b0, 3'd0, 1'b1, 32'd1024, 24'h000040, 64'h7000, pn);
    drain(-1, 0, -1, 2, pn);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({m_desc_valid, busy, transfer_done} !== 3'b000) begin
      errors++; $display("FAIL abort_state valid/busy/done: got %b expected 000", {m_desc_valid, busy, transfer_done});
    end
    @(posedge clk); #1;
    checks++;
    if (transfer_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %0b expected 0", transfer_done); end
    start_wr(1'b0, 1'b0, 3'd0, 1'b1, 32'd600, 24'hABCDE0, 64'h9000, pn);
    drain(-1, 0, -1, -1, pn);
  endtask

  initial begin
    test_reset();
    test_write_segmented();
    test_send_imm_zero();
    test_psn_wrap();
    test_write_only_and_stall();
    test_drop();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/roce_tx_wr_segmenter.md
Name: roce_tx_wr_segmenter

Overview:
- Sits directly downstream of the UDP RoCE connection manager. Consumes its QP parameters and start_transfer pulse.
- Splits one DMA work request into a stream of per-packet RoCE RC descriptors: opcode, PSN, length, RETH fields, ack-request. Each descriptor is sized to the path MTU.
- Descriptors feed the RoCE BTH/RETH header builder through a valid/ready handshake, at most one per cycle.

Parameters:
- LEN_W, 32, width of the DMA length and remaining-bytes counter.
- DEFAULT_PMTU, 3'd4, PMTU code applied while pmtu_valid is low.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high. Single clock domain.
- start_transfer  in  1  single-cycle pulse that launches a work request.
- dma_transfer  in  32  transfer length in bytes.
- r_key  in  32  remote key.
- rem_qpn  in  24  destination QP.
- loc_psn  in  24  starting PSN.
- rem_addr  in  64  remote virtual address.
- rem_ip_addr  in  32  destination IP.
- is_immediate  in  1  use the IMM variant of the LAST/ONLY opcode.
- tx_type  in  1  0 = SEND, 1 = RDMA WRITE.
- pmtu  in  3  MTU code: 0=256, 1=512, 2=1024, 3=2048, 4=4096; 5-7 are treated as 4.
- pmtu_valid  in  1  when low, DEFAULT_PMTU is used instead of pmtu.
- m_desc_valid  out  1  descriptor valid.
- m_desc_ready  in  1  descriptor accept.
- m_bth_op_code  out  8  RC opcode.
- m_bth_psn  out  24  packet PSN.
- m_bth_dest_qp  out  24  copy of rem_qpn.
- m_bth_ack_req  out  1  set on LAST/ONLY packets.
- m_reth_valid  out  1  RETH is present: WRITE_FIRST or WRITE_ONLY.
- m_reth_v_addr  out  64  segment start address.
- m_reth_r_key  out  32  remote key.
- m_reth_length  out  32  total DMA length.
- m_payload_length  out  13  payload bytes in this packet.
- m_ip_dest_ip  out  32  destination IP.
- m_is_last  out  1  final descriptor of the work request.
- psn_next  out  24  PSN after the last emitted packet.
- transfer_done  out  1  one-cycle pulse.
- start_dropped  out  1  one-cycle pulse.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE. The following outputs are 0: m_desc_valid, transfer_done, start_dropped, busy, psn_next. All descriptor field registers are also 0.
- Capture (IDLE, start_transfer=1):
  - Latch all inputs and the effective PMTU in the same cycle.
  - Set remaining = dma_transfer, psn = loc_psn, vaddr = rem_addr, first = 1.
  - Go to SEGMENT. m_desc_valid rises on the next cycle (latency 1).
- SEGMENT: descriptor outputs are registered and held stable while m_desc_valid=1 and m_desc_ready=0.
  - On each handshake the next descriptor is loaded the same cycle, so back-to-back emission is one per cycle.
  - Packet length = min(remaining, PMTU_bytes). Then remaining -= len, vaddr += len, psn = (psn+1) mod 2^24, first = 0.
- Opcode selection:
  - SEND: FIRST 0x00, MIDDLE 0x01, LAST 0x02 / 0x03 (imm), ONLY 0x04 / 0x05 (imm).
  - WRITE: FIRST 0x06, MIDDLE 0x07, LAST 0x08 / 0x09 (imm), ONLY 0x0A / 0x0B (imm).
  - ONLY when first and remaining <= PMTU. LAST when not first and remaining <= PMTU. Otherwise FIRST (if first) or MIDDLE.
- Zero length: a single ONLY descriptor with m_payload_length=0.
- Exact multiple of PMTU: the last packet carries a full PMTU. No empty trailing packet is generated.
- m_reth_v_addr carries the segment address on every descriptor. m_reth_valid is set only on WRITE FIRST/ONLY.
- End of transfer: handshake on the m_is_last descriptor. In the following cycle:
  - psn_next = last PSN + 1 (mod 2^24).
  - transfer_done pulses for one cycle.
  - m_desc_valid is low.
  - State returns to IDLE.
- start_transfer arriving in SEGMENT is ignored. start_dropped pulses the next cycle and the captured values are unchanged.
- A start in the same cycle as the final handshake is also dropped. IDLE must be reached first.
- Input changes after capture have no effect.
- rst asserted mid-transfer aborts immediately: no transfer_done, valid drops in the next cycle.
- Arithmetic: vaddr adds 64-bit with wrap. The remaining counter is LEN_W wide and never underflows.

Decomposition:
- Shared package roce_pkg:
  - Opcode localparams ROCE_SEND_FIRST … ROCE_RDMA_WRITE_ONLY_IMM.
  - PMTU code enum.
  - Function pmtu_bytes(code) returning 13 bits.
- One natural combinational sub-module: roce_opcode_sel, taking (tx_type, is_immediate, first, last) and returning the 8-bit opcode. It is reused by the header builder.

Test Plan:
- WRITE, pmtu=1, len=1300, loc_psn=0x000010, rem_addr=0x1000 -> three descriptors:
  - 0x06 / 512 / psn 0x10 / vaddr 0x1000 / reth_valid.
  - 0x07 / 512 / 0x11 / 0x1200.
  - 0x08 / 276 / 0x12 / 0x1400 / ack_req / is_last.
  - Then transfer_done, psn_next=0x13.
- SEND with immediate, len=0 -> one descriptor 0x05, payload 0, ack_req, reth_valid=0; psn_next = loc_psn+1.
- WRITE, pmtu=4, len=8192, loc_psn=0xFFFFFF -> 0x06 psn 0xFFFFFF, then 0x08 psn 0x000000 with length 4096; psn_next=0x000001.
- len=4096, pmtu=4, WRITE -> a single 0x0A descriptor of 4096 bytes. Also with m_desc_ready held low for 5 cycles mid-transfer, all fields must stay stable and no descriptor is skipped or duplicated.
- start_transfer pulsed during SEGMENT with different dma_transfer -> start_dropped pulses; the remaining descriptors use the original length.
- rst asserted after the 2nd of 4 descriptors -> next cycle m_desc_valid=0, busy=0, no transfer_done; a new start then begins at the newly supplied loc_psn.
